paralelo_serie_tx: RTL and testbench

PARALELO_SERIE_TX -- requirements
Module: paralelo_serie_tx

---
 rtl/paralelo_serie_tx_pkg.sv | 13 +
 rtl/paralelo_serie_tx.sv | 56 +++++
 tb/tb_paralelo_serie_tx.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/paralelo_serie_tx_pkg.sv
// Shared constants and FSM state encoding for the parallel-to-serial link transmitter.
package paralelo_serie_tx_pkg;

  localparam int         BYTE_W       = 8;
  localparam int         PREAMBLE_LEN = 4;
  localparam logic [7:0] COMMA_BYTE   = 8'hBC;

  typedef enum logic {
    PREAMBLE = 1'b0,
    ACTIVE   = 1'b1
  } state_t;

endpackage

// File: rtl/paralelo_serie_tx.sv
// Byte-to-serial transmitter: 4-comma preamble, then one byte per 8-cycle slot, MSB first.
// Optional PARALELO_SERIE_FRAME_EN adds frame_out, high on the MSB cycle of every slot.
module paralelo_serie_tx
  import paralelo_serie_tx_pkg::*;
(
  input  logic              clk_8f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              active_out,
  output logic              data_out
`ifdef PARALELO_SERIE_FRAME_EN
  ,
  output logic              frame_out
`endif
);

  state_t            state;
  logic [1:0]        sync_cnt;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] shreg;

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      // bit_cnt=7 makes the first edge after release a load edge
      state    <= PREAMBLE;
      sync_cnt <= 2'd0;
      bit_cnt  <= 3'd7;
      shreg    <= '0;
    end else if (bit_cnt == 3'd7) begin
      bit_cnt <= 3'd0;
      case (state)
        PREAMBLE: begin
          shreg    <= COMMA_BYTE;
          sync_cnt <= sync_cnt + 2'd1;
          if (sync_cnt == 2'(PREAMBLE_LEN - 1)) state <= ACTIVE;
        end
        ACTIVE: shreg <= valid_in ? data_in : COMMA_BYTE;
        default: state <= PREAMBLE;
      endcase
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      shreg   <= {shreg[BYTE_W-2:0], 1'b0};
    end
  end

  assign data_out   = shreg[BYTE_W-1];
  assign active_out = (state == ACTIVE);
  assign ready_out  = (state == ACTIVE) && (bit_cnt == 3'd7);

`ifdef PARALELO_SERIE_FRAME_EN
  assign frame_out = (bit_cnt == 3'd0) && !reset;
`endif

endmodule

// File: tb/tb_paralelo_serie_tx.sv
// Randomized self-checking bench for paralelo_serie_tx against a slot-level reference model.
module tb_paralelo_serie_tx;

  logic       clk_8f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       active_out;
  logic       data_out;
`ifdef PARALELO_SERIE_FRAME_EN
  logic       frame_out;
`endif

  paralelo_serie_tx dut (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .active_out(active_out),
    .data_out  (data_out)
`ifdef PARALELO_SERIE_FRAME_EN
    ,
    .frame_out (frame_out)
`endif
  );

  always #5 clk_8f = ~clk_8f;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: edges since reset release, and the byte occupying the current slot.
  int         mcyc  = 0;
  logic [7:0] mbyte = 8'h00;

  function automatic logic exp_bit();
    int idx;
    if (mcyc == 0) return 1'b0;
    idx = 7 - ((mcyc - 1) % 8);
    return mbyte[idx];
  endfunction

  task automatic tick(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk_8f);
    if (reset) begin
      mcyc  = 0;
      mbyte = 8'h00;
    end else begin
      mcyc++;
      if ((mcyc - 1) % 8 == 0)
        mbyte = (((mcyc - 1) / 8) < 4) ? 8'hBC : (v ? d : 8'hBC);
    end
    @(negedge clk_8f);
  endtask

  // One full slot starting from a load-pending cycle; collects the observed bits.
  task automatic send_slot(input logic v, input logic [7:0] d, input bit junk,
                           output logic [7:0] got, output logic [7:0] rdyp,
                           output logic [7:0] actp, output int bit_err);
    got = '0; rdyp = '0; actp = '0; bit_err = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)                      tick(v, d);
      else if (junk && i >= 2 && i <= 5) tick(1'b1, 8'h55);
      else                             tick(1'b0, 8'($urandom));
      got  = {got[6:0], data_out};
      rdyp = {rdyp[6:0], ready_out};
      actp = {actp[6:0], active_out};
      if (data_out !== exp_bit()) bit_err++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'hFF);
      n_total++;
      if ({data_out, ready_out, active_out} !== 3'b000) begin
        $display("FAIL reset_state: got do/rdy/act=%b required 000", {data_out, ready_out, active_out});
      end else n_pass++;
    end
  endtask

  task automatic test_preamble(input string tag);
    logic [7:0] got, rdyp, actp;
    int         be;
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      send_slot(1'b0, 8'h00, 1'b0, got, rdyp, actp, be);
      n_total++;
      if (got !== 8'hBC || be !== 0) begin
        $display("FAIL %s_byte%0d: got %h (bit errors %0d) required bc", tag, s, got, be);
      end else n_pass++;
      n_total++;
      if (actp !== ((s == 3) ? 8'hFF : 8'h00)) begin
        $display("FAIL %s_active%0d: got %b required %b", tag, s, actp, (s == 3) ? 8'hFF : 8'h00);
      end else n_pass++;
      n_total++;
      if (rdyp !== ((s == 3) ? 8'h01 : 8'h00)) begin
        $display("FAIL %s_ready%0d: got %b required %b", tag, s, rdyp, (s == 3) ? 8'h01 : 8'h00);
      end else n_pass++;
    end
  endtask

  task automatic test_single();
    logic [7:0] got, rdyp, actp;
    int         be;
    send_slot(1'b1, 8'hA5, 1'b0, got, rdyp, actp, be);
    n_total++;
    if (got !== 8'b1010_0101 || be !== 0 || rdyp !== 8'h01) begin
      $display("FAIL single_a5: got %h rdy %b (bit errors %0d) required a5 rdy 00000001", got, rdyp, be);
    end else n_pass++;
    send_slot(1'b0, 8'h00, 1'b0, got, rdyp, actp, be);
    n_total++;
    if (got !== 8'hBC || be !== 0) begin
      $display("FAIL single_idle: got %h required bc", got);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  got, rdyp, actp;
    logic [7:0]  bytes [3];
    logic [23:0] stream;
    int          be, tot_be;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    stream = '0; tot_be = 0;
    for (int k = 0; k < 3; k++) begin
      send_slot(1'b1, bytes[k], 1'b0, got, rdyp, actp, be);
      stream = {stream[15:0], got};
      tot_be += be;
    end
    n_total++;
    if (stream !== 24'h00FF3C || tot_be !== 0) begin
      $display("FAIL back_to_back: got %h (bit errors %0d) required 00ff3c", stream, tot_be);
    end else n_pass++;
  endtask

  task automatic test_comma_data();
    logic [7:0] got, rdyp, actp;
    int         be;
    send_slot(1'b1, 8'hBC, 1'b0, got, rdyp, actp, be);
    n_total++;
    if (got !== 8'hBC || be !== 0) begin
      $display("FAIL comma_data: got %h required bc", got);
    end else n_pass++;
  endtask

  task automatic test_ignored_valid();
    logic [7:0] got, rdyp, actp;
    int         be;
    for (int k = 0; k < 2; k++) begin
      send_slot(1'b0, 8'h55, (k == 0), got, rdyp, actp, be);
      n_total++;
      if (got !== 8'hBC || be !== 0) begin
        $display("FAIL ignored_valid%0d: got %h required bc", k, got);
      end else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [7:0] got, rdyp, actp, d, want;
    logic       v;
    int         be;
    for (int k = 0; k < 16; k++) begin
      v    = 1'($urandom_range(1, 0));
      d    = 8'($urandom);
      want = v ? d : 8'hBC;
      send_slot(v, d, 1'b0, got, rdyp, actp, be);
      n_total++;
      if (got !== want || be !== 0 || rdyp !== 8'h01) begin
        $display("FAIL random%0d: got %h rdy %b (bit errors %0d) required %h", k, got, rdyp, be, want);
      end else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    tick(1'b1, 8'hC3);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00);
    reset = 1'b1;
    tick(1'b1, 8'hFF);
    n_total++;
    if ({data_out, ready_out, active_out} !== 3'b000) begin
      $display("FAIL mid_reset: got do/rdy/act=%b required 000", {data_out, ready_out, active_out});
    end else n_pass++;
    tick(1'b0, 8'h00);
    test_preamble("re_preamble");
  endtask

  task automatic test_loopback();
    logic [7:0] got, rdyp, actp, rx [$];
    int         be;
    send_slot(1'b1, 8'h12, 1'b0, got, rdyp, actp, be);
    if (be == 0) rx.push_back(got);
    send_slot(1'b1, 8'h34, 1'b0, got, rdyp, actp, be);
    if (be == 0) rx.push_back(got);
    n_total++;
    if (rx.size() !== 2) begin
      $display("FAIL loopback_count: got %0d bytes required 2", rx.size());
    end else begin
      n_pass++;
      n_total++;
      if (rx[0] !== 8'h12 || rx[1] !== 8'h34) begin
        $display("FAIL loopback_data: got %h %h required 12 34", rx[0], rx[1]);
      end else n_pass++;
    end
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    @(negedge clk_8f);
    test_reset();
    test_preamble("preamble");
    test_single();
    test_back_to_back();
    test_comma_data();
    test_ignored_valid();
    test_random();
    test_mid_reset();
    test_loopback();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
